// File: rtl/xy_output_port_arbiter_pkg.sv
// Shared router definitions: port indices, AXIS flit payload and arbiter state.
package xy_output_port_arbiter_pkg;

  localparam int unsigned N_PORTS         = 5;
  localparam int unsigned AXIS_DATA_WIDTH = 32;
  localparam int unsigned AXIS_ID_WIDTH   = 3;

  typedef enum logic [2:0] {
    PORT_HOME  = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_ID_WIDTH-1:0]   id;
    logic                       last;
  } axis_flit_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n ports (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xy_output_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, circularly.
module xy_output_port_arbiter_rr_pick
  import xy_output_port_arbiter_pkg::*;
#(
  parameter int unsigned N  = N_PORTS,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_c
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant_c[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xy_output_port_arbiter.sv
// Wormhole output-port arbiter: packet-locked round-robin grant plus output register.
module xy_output_port_arbiter
  import xy_output_port_arbiter_pkg::*;
#(
  parameter int unsigned N_INPUTS   = N_PORTS,
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = AXIS_ID_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            req_i,
  input  logic [N_INPUTS-1:0]            s_tvalid_i,
  output logic [N_INPUTS-1:0]            s_tready_o,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_INPUTS*ID_WIDTH-1:0]   s_tid_i,
  input  logic [N_INPUTS-1:0]            s_tlast_i,
  output logic                           m_tvalid_o,
  input  logic                           m_tready_i,
  output logic [DATA_WIDTH-1:0]          m_tdata_o,
  output logic [ID_WIDTH-1:0]            m_tid_o,
  output logic                           m_tlast_o,
  output logic [N_INPUTS-1:0]            grant_o,
  output logic                           busy_o
);

  localparam int unsigned PW = ptr_width(N_INPUTS);

  arb_state_e            state;
  logic [PW-1:0]         ptr;
  logic [N_INPUTS-1:0]   req_c;
  logic [N_INPUTS-1:0]   pick_c;
  logic                  out_space_c;
  logic                  accept_c;
  logic [PW-1:0]         gidx_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic [ID_WIDTH-1:0]   sel_id_c;
  logic                  sel_last_c;

  assign req_c       = req_i & s_tvalid_i;
  assign out_space_c = !m_tvalid_o || m_tready_i;
  assign s_tready_o  = ((state == ARB_LOCKED) && out_space_c) ? grant_o : '0;
  assign accept_c    = |(s_tready_o & s_tvalid_i);
  assign busy_o      = (state == ARB_LOCKED);

  xy_output_port_arbiter_rr_pick #(
    .N  (N_INPUTS),
    .PW (PW)
  ) u_rr_pick (
    .req     (req_c),
    .ptr     (ptr),
    .grant_c (pick_c)
  );

  // Mux the granted input's flit and index.
  always_comb begin
    gidx_c     = '0;
    sel_data_c = '0;
    sel_id_c   = '0;
    sel_last_c = 1'b0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (grant_o[k]) begin
        gidx_c     = PW'(k);
        sel_data_c = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_id_c   = s_tid_i[k*ID_WIDTH +: ID_WIDTH];
        sel_last_c = s_tlast_i[k];
      end
    end
  end

  // Arbitration FSM, grant register and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      ptr        <= PW'(N_INPUTS - 1);
      grant_o    <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tid_o    <= '0;
      m_tlast_o  <= 1'b0;
    end else begin
      if (accept_c) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= sel_data_c;
        m_tid_o    <= sel_id_c;
        m_tlast_o  <= sel_last_c;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (|req_c) begin
            grant_o <= pick_c;
            state   <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // Release only when the packet's tail flit is taken.
          if (accept_c && sel_last_c) begin
            ptr     <= gidx_c;
            grant_o <= '0;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xy_output_port_arbiter.sv
// Randomized scoreboard bench for the wormhole output-port arbiter.
module tb_xy_output_port_arbiter;
  import xy_output_port_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, s_tvalid_i, s_tready_o, s_tlast_i;
  logic [N*DW-1:0] s_tdata_i;
  logic [N*IW-1:0] s_tid_i;
  logic            m_tvalid_o, m_tready_i, m_tlast_o, busy_o;
  logic [DW-1:0]   m_tdata_o;
  logic [IW-1:0]   m_tid_o;
  logic [N-1:0]    grant_o;

  xy_output_port_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .s_tdata_i(s_tdata_i), .s_tid_i(s_tid_i), .s_tlast_i(s_tlast_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
    .m_tid_o(m_tid_o), .m_tlast_o(m_tlast_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source state per input
  logic          src_valid[N];
  logic [DW-1:0] src_data[N];
  logic [IW-1:0] src_id[N];
  int            src_left[N];
  int            src_seq[N];
  int            fixed_src = -1;
  int            p_start = 0, p_ready = 100, p_cont = 100, len_max = 1;
  bit            stop_new = 1'b1, hog4 = 1'b0;
  logic [N-1:0]  fire;

  // Reference model (packet-level round robin with one output slot)
  bit            mdl_locked;
  int            mdl_owner;
  int            mdl_ptr;
  bit            mdl_full;
  axis_flit_t    exp_q[$];

  // Fairness tracking from observed grants
  int            wait_cnt[N];
  int            max_wait = 0;
  logic [N-1:0]  prev_grant, prev_req;

  task automatic new_payload(input int k);
    if (k == fixed_src) src_data[k] = 32'hA1 + DW'(src_seq[k]);
    else                src_data[k] = $urandom;
    src_id[k] = IW'($urandom_range(0, 7));
    src_seq[k]++;
  endtask

  task automatic start_packet(input int k, input int len);
    src_left[k]  = len;
    src_seq[k]   = 0;
    new_payload(k);
    src_valid[k] = 1'b1;
  endtask

  task automatic next_flit(input int k);
    src_left[k]--;
    if (src_left[k] > 0) begin
      new_payload(k);
      src_valid[k] = ($urandom_range(0, 99) < p_cont);
    end else begin
      src_valid[k] = 1'b0;
    end
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      s_tvalid_i[k]          = src_valid[k];
      req_i[k]               = src_valid[k] | ($urandom_range(0, 3) == 0);
      s_tdata_i[k*DW +: DW]  = src_data[k];
      s_tid_i[k*IW +: IW]    = src_id[k];
      s_tlast_i[k]           = (src_left[k] == 1);
    end
    m_tready_i = ($urandom_range(0, 99) < p_ready);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (fire[k]) next_flit(k);
      else if (src_left[k] == 0) begin
        if (!stop_new && ((hog4 && k == 4) || $urandom_range(0, 99) < p_start))
          start_packet(k, $urandom_range(1, len_max));
      end else if (!src_valid[k]) begin
        src_valid[k] = ($urandom_range(0, 99) < 70);
      end
    end
    fire = '0;
    apply();
  endtask

  task automatic model_reset();
    mdl_locked = 1'b0; mdl_owner = 0; mdl_ptr = N - 1; mdl_full = 1'b0;
    exp_q.delete();
    prev_grant = '0; prev_req = '0;
    for (int k = 0; k < N; k++) begin
      wait_cnt[k] = 0; src_left[k] = 0; src_valid[k] = 1'b0; src_seq[k] = 0;
    end
    fire = '0;
  endtask

  // Compare DUT control outputs to the model, then advance the model one cycle.
  task automatic model_step();
    logic [N-1:0] one, req, exp_grant, exp_ready;
    bit acc;
    one       = 1;
    req       = req_i & s_tvalid_i;
    exp_grant = mdl_locked ? (one << mdl_owner) : '0;
    exp_ready = (mdl_locked && (!mdl_full || m_tready_i)) ? exp_grant : '0;
    check("grant", 64'(grant_o), 64'(exp_grant));
    check("s_tready", 64'(s_tready_o), 64'(exp_ready));
    check("busy", 64'(busy_o), 64'(mdl_locked));
    check("m_tvalid", 64'(m_tvalid_o), 64'(mdl_full));
    fire = s_tvalid_i & s_tready_o;

    if (grant_o != '0 && prev_grant == '0) begin
      for (int k = 0; k < N; k++) begin
        if (grant_o[k]) wait_cnt[k] = 0;
        else if (prev_req[k]) begin
          wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
    end
    prev_grant = grant_o;
    prev_req   = req;

    if (mdl_locked) begin
      acc = exp_ready[mdl_owner] && s_tvalid_i[mdl_owner];
      if (acc) begin
        exp_q.push_back('{data: src_data[mdl_owner], id: src_id[mdl_owner],
                          last: (src_left[mdl_owner] == 1)});
        mdl_full = 1'b1;
        if (src_left[mdl_owner] == 1) begin
          mdl_ptr    = mdl_owner;
          mdl_locked = 1'b0;
        end
      end else if (m_tready_i) begin
        mdl_full = 1'b0;
      end
    end else begin
      if (m_tready_i) mdl_full = 1'b0;
      if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (req[(mdl_ptr + i) % N]) begin
            mdl_owner = (mdl_ptr + i) % N;
            break;
          end
        end
        mdl_locked = 1'b1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_tvalid_o), 64'(0));
    check({tag, "_m_tdata"},  64'(m_tdata_o),  64'(0));
    check({tag, "_m_tid"},    64'(m_tid_o),    64'(0));
    check({tag, "_m_tlast"},  64'(m_tlast_o),  64'(0));
    check({tag, "_grant"},    64'(grant_o),    64'(0));
    check({tag, "_busy"},     64'(busy_o),     64'(0));
    check({tag, "_s_tready"}, 64'(s_tready_o), 64'(0));
  endtask

  task automatic cycle_step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Mid-packet asynchronous reset, then inputs 0 and 3 contend.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    model_reset();
    apply();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    start_packet(0, 1);
    start_packet(3, 1);
    apply();
  endtask

  // Output monitor: pop and compare every flit leaving the output register.
  initial begin
    axis_flit_t f;
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got data 0x%0h with no flit expected at %0t", m_tdata_o, $time);
        end else begin
          f = exp_q.pop_front();
          check("out_data", 64'(m_tdata_o), 64'(f.data));
          check("out_id",   64'(m_tid_o),   64'(f.id));
          check("out_last", 64'(m_tlast_o), 64'(f.last));
        end
      end
    end
  end

  initial begin
    bit reset_done = 1'b0;
    bit drained    = 1'b0;
    rst = 1'b1;
    model_reset();
    apply();
    m_tready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) start_packet(k, 1);
    apply();

    for (int cyc = 0; cyc < 3600; cyc++) begin
      if (cyc == 30) begin
        fixed_src = 2; p_cont = 100;
      end
      if (cyc == 40) begin
        fixed_src = -1; stop_new = 1'b0; p_start = 30; p_ready = 75; p_cont = 80; len_max = 4;
      end
      if (cyc == 1500) p_ready = 30;
      if (cyc == 2500) begin
        hog4 = 1'b1; p_start = 10; p_ready = 90;
      end
      cycle_step();
      if (cyc == 30) begin
        start_packet(2, 3);
        apply();
      end
      if (cyc >= 1200 && !reset_done && mdl_locked && src_left[mdl_owner] >= 2 && src_seq[mdl_owner] >= 2) begin
        reset_done = 1'b1;
        do_reset();
      end
    end

    stop_new = 1'b1; hog4 = 1'b0; p_ready = 100; p_cont = 100;
    for (int i = 0; i < 500 && !drained; i++) begin
      cycle_step();
      drained = !mdl_locked && !mdl_full && exp_q.size() == 0;
      for (int k = 0; k < N; k++) if (src_left[k] != 0) drained = 1'b0;
    end
    check("drain_complete", 64'(drained), 64'(1));
    check("reset_exercised", 64'(reset_done), 64'(1));
    check("fairness_max_wait_ok", 64'(max_wait <= N - 1), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xy_output_port_arbiter.md
# xy_output_port_arbiter

Wormhole output-port arbiter and output register for one virtual network (REQ or RESP) of one XY mesh router. It shares a single outgoing AXI-Stream link (HOME, NORTH, EAST, SOUTH or WEST) among the five input ports whose route computation selected it. It holds a grant for a whole packet, from head flit to TLAST, and rotates priority round-robin between packets. One instance is used per output port per virtual network inside the dual router.

## Interface
Parameters:
- N_INPUTS, 5, number of competing input ports; index 0 = HOME, 1 = NORTH, 2 = EAST, 3 = SOUTH, 4 = WEST.
- DATA_WIDTH, 32, AXIS channel TDATA width (mesh AXIS_CHANNEL_WIDTH).
- ID_WIDTH, 3, TID width.

Ports:
- clk  in  1  router clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  N_INPUTS  bit k: input k's current packet is routed to this output; qualified by s_tvalid_i[k].
- s_tvalid_i  in  N_INPUTS  per-input flit valid.
- s_tready_o  out  N_INPUTS  per-input ready; only the granted bit can be 1.
- s_tdata_i  in  N_INPUTS*DATA_WIDTH  packed flit data; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_tid_i  in  N_INPUTS*ID_WIDTH  packed TID.
- s_tlast_i  in  N_INPUTS  per-input end-of-packet.
- m_tvalid_o  out  1  output flit valid (registered).
- m_tready_i  in  1  downstream ready.
- m_tdata_o  out  DATA_WIDTH  registered output data.
- m_tid_o  out  ID_WIDTH  registered output TID.
- m_tlast_o  out  1  registered output TLAST.
- grant_o  out  N_INPUTS  one-hot current owner; all zero when idle.
- busy_o  out  1  1 while in LOCKED.

## Operation
- Request vector: req = req_i & s_tvalid_i.
- FSM has two states, IDLE and LOCKED.
- IDLE: when req != 0, pick the first set bit searching circularly from ptr+1. Register grant_o and move to LOCKED. s_tready_o stays 0 in IDLE.
- LOCKED:
  - s_tready_o[g] = !m_tvalid_o | m_tready_i, where g is the granted input.
  - On an accept (s_tvalid_i[g] & s_tready_o[g]), the output register loads data, TID and TLAST from input g and sets m_tvalid_o.
  - When the accepted flit has TLAST=1: set ptr <= g, clear grant_o, return to IDLE.
- In LOCKED, changes on req_i or on other inputs are ignored. The packet stays locked until its TLAST is accepted.
- Output register:
  - If m_tvalid_o & m_tready_i and there is no new accept, clear m_tvalid_o.
  - Payload holds stable while m_tvalid_o & !m_tready_i.
- Fairness: a continuously requesting input waits at most N_INPUTS-1 packets.

## Timing
- Reset values:
  - state = IDLE, ptr = N_INPUTS-1 (input 0 has first priority).
  - grant_o = 0, busy_o = 0, s_tready_o = 0.
  - m_tvalid_o = 0, m_tdata_o = 0, m_tid_o = 0, m_tlast_o = 0.
- Arbitration latency: a request seen in IDLE at cycle t gives a grant at t+1. The first s_tready_o is possible at t+1, and the first m_tvalid_o at t+2.
- Flit latency: accept at cycle c gives m_tvalid_o at c+1.
- Throughput: 1 flit/cycle while locked, as long as m_tready_i stays high.
- Between packets there is always exactly one IDLE bubble cycle, including back-to-back packets from the same input.
- Single-flit packet: IDLE → LOCKED → IDLE, with one accept cycle.
- Downstream stall: s_tready_o[g] is 0 whenever the output register is full and m_tready_i = 0. No flit is lost or duplicated.
- Simultaneous TLAST accept and downstream drain: both happen in the same cycle.
- Reset asserted mid-packet: all state clears immediately (asynchronously). The partial packet is dropped and the output register is emptied.

## Structure
- Shared router package holds:
  - port index enum (HOME, NORTH, EAST, SOUTH, WEST);
  - N_PORTS = 5;
  - the AXIS flit struct (data, id, last) reused by router_dual.
- Sub-module rr_pick: combinational, takes req[N] and ptr, returns a one-hot grant. It is instantiated once and reusable by input-side allocators.
- The FSM, grant register and output register live in this module.

## Test plan
- Reset, then input 2 sends a 3-flit packet with data 0xA1, 0xA2, 0xA3 (TLAST on the last), m_tready_i = 1 → grant_o = 00100 one cycle after the request. Output shows 0xA1..0xA3 on consecutive cycles starting 2 cycles after the request, and TLAST is seen only with 0xA3.
- All five inputs request simultaneously with 1-flit packets → service order 0, 1, 2, 3, 4. Each packet is separated by one idle cycle.
- Input 1 is mid-packet (4 flits) and input 0 raises a request → input 0 gets no s_tready until input 1's TLAST is accepted. Input 0 is granted next.
- m_tready_i is held 0 for 5 cycles mid-packet → m_tdata_o stays constant and s_tready_o[g] = 0 throughout. All flits arrive in order once ready returns.
- rst is pulsed during the second flit of a 4-flit packet → all outputs are 0 in the same cycle. After release, a new request from input 0 is granted before input 3.
- Input 4 requests continuously and input 3 requests once → input 3 is served after at most one packet from input 4.
